jk_drive_sequencer: RTL and testbench

//   Upstream command stage for the jkff flip-flop. Takes JK operations (hold/reset/set/toggle)

---
 rtl/jk_pkg.sv | 14 +
 rtl/jk_ref_model.sv | 35 +++
 rtl/jk_drive_sequencer.sv | 120 ++++++++++++
 tb/tb_jk_drive_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared JK operation codes and sequencer state encodings.
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/jk_ref_model.sv
// Reference JK flip-flop: tracks the q the downstream jkff should hold given the j/k driven to it.
module jk_ref_model
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic exp_q
);

    logic exp_q_q;
    logic exp_q_d;

    always_comb begin
        exp_q_d = exp_q_q;
        case ({j, k})
            JK_HOLD:  exp_q_d = exp_q_q;
            JK_RESET: exp_q_d = 1'b0;
            JK_SET:   exp_q_d = 1'b1;
            default:  exp_q_d = ~exp_q_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q_q <= 1'b0;
        end else begin
            exp_q_q <= exp_q_d;
        end
    end

    assign exp_q = exp_q_q;

endmodule

// File: rtl/jk_drive_sequencer.sv
// Drives jkff j/k with a captured op for cmd_len cycles; optional q checking under JK_CHECK_EN.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; cmd_ready is high only in IDLE.
module jk_drive_sequencer
    import jk_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    output logic             j,
    output logic             k,
    input  logic             q_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             dbg_state_o
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        state_d = ST_DRIVE;
                        j_d     = cmd_op[1];
                        k_d     = cmd_op[0];
                        cnt_d   = cmd_len;
                        busy_d  = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                // The edge that consumes the last count is also the one that returns j/k to hold.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready   = rst && (state_q == ST_IDLE);
    assign j           = j_q;
    assign k           = k_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

`ifdef JK_CHECK_EN
    logic exp_q;
    logic err_q;

    jk_ref_model u_ref_model (
        .clk   (clk),
        .rst   (rst),
        .j     (j_q),
        .k     (k_q),
        .exp_q (exp_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (q_in != exp_q) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_q_in;
    assign unused_q_in = q_in;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Bench for jk_drive_sequencer driving a behavioural jkff; observes outputs on falling edges.
module tb_jk_drive_sequencer;

`ifdef JK_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_len;
    logic       j, k;
    logic       q_in;
    logic       busy, done, err;
    logic       dbg_state;
    logic       q;
    logic       q_flip;
    logic       jk_rst;

    int         tests_run;
    int         tests_failed;
    logic       m_q;
    logic [6:0] exp_q[$];

    jk_drive_sequencer #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_len     (cmd_len),
        .j           (j),
        .k           (k),
        .q_in        (q_in),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset / downstream jkff ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign jk_rst = ~rst;
    always_ff @(posedge clk or posedge jk_rst) begin
        if (jk_rst) q <= 1'b0;
        else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end
    assign q_in = q ^ q_flip;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference: q after n sampled edges of op ----------------
    function automatic logic apply_op(input logic q0, input logic [1:0] op, input int n);
        if (n == 0) return q0;
        case (op)
            2'b00:   return q0;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return q0 ^ n[0];
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic accept_cmd(input logic [1:0] op, input int len);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL accept_wait: cmd_ready=%b required 1 within 100 cycles", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = 8'(len);
        @(posedge clk);
    endtask

    // Sends one command and checks {j,k,cmd_ready,busy,done,q,err} on every cycle of its run.
    task automatic run_cmd(input string name, input logic [1:0] op, input int len, input bit noisy);
        logic       q0;
        logic [6:0] exp_v;
        logic [6:0] obs;
        logic [1:0] jk;
        q0 = m_q;
        accept_cmd(op, len);
        for (int i = 0; i <= len; i++) begin
            jk = (i < len) ? op : 2'b00;
            exp_q.push_back({jk, (i >= len), (i < len), (i == len), apply_op(q0, op, i), 1'b0});
        end
        exp_q.push_back({2'b00, 1'b1, 1'b0, 1'b0, apply_op(q0, op, len), 1'b0});
        for (int i = 0; i <= len + 1; i++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            obs   = {j, k, cmd_ready, busy, done, q, err};
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL %s step %0d: {j,k,rdy,busy,done,q,err} got %b required %b",
                         name, i, obs, exp_v);
            end
            if (noisy && i < len) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_len   = 8'($urandom_range(0, 255));
            end else begin
                cmd_valid = 1'b0;
            end
        end
        m_q = apply_op(q0, op, len);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #3;
        tests_run++;
        if ({j, k, cmd_ready, busy, done, err, q} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_early: {j,k,rdy,busy,done,err,q} got %b required 0000000",
                     {j, k, cmd_ready, busy, done, err, q});
        end
        #8;
        tests_run++;
        if ({j, k, cmd_ready, busy, done, err, q} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_late: {j,k,rdy,busy,done,err,q} got %b required 0000000",
                     {j, k, cmd_ready, busy, done, err, q});
        end
        #1 rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({j, k, cmd_ready, busy, done, err, q} !== 7'b0010000) begin
            tests_failed++;
            $display("FAIL reset_release: {j,k,rdy,busy,done,err,q} got %b required 0010000",
                     {j, k, cmd_ready, busy, done, err, q});
        end
        m_q = 1'b0;
    endtask

    task automatic test_set_toggle();
        run_cmd("set_len3", 2'b10, 3, 1'b0);
        run_cmd("toggle_len4", 2'b11, 4, 1'b0);
    endtask

    task automatic test_len_zero();
        run_cmd("reset_len0", 2'b01, 0, 1'b0);
        run_cmd("set_len1", 2'b10, 1, 1'b0);
        run_cmd("reset_len0_b", 2'b01, 0, 1'b0);
    endtask

    task automatic test_valid_during_drive();
        run_cmd("noisy_toggle5", 2'b11, 5, 1'b1);
        run_cmd("noisy_reset6", 2'b01, 6, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        logic q0;
        q0 = m_q;
        accept_cmd(2'b11, 10);
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            tests_run++;
            if ({j, k, busy, done, q} !== {2'b11, 1'b1, 1'b0, q0 ^ i[0]}) begin
                tests_failed++;
                $display("FAIL midrun_drive step %0d: {j,k,busy,done,q} got %b required %b",
                         i, {j, k, busy, done, q}, {2'b11, 1'b1, 1'b0, q0 ^ i[0]});
            end
        end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({j, k, cmd_ready, busy, done, q, err} !== 7'b0) begin
            tests_failed++;
            $display("FAIL midrun_async_reset: {j,k,rdy,busy,done,q,err} got %b required 0000000",
                     {j, k, cmd_ready, busy, done, q, err});
        end
        @(negedge clk);
        #2 rst = 1'b1;
        m_q = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({j, k, cmd_ready, busy, done} !== 5'b00100) begin
                tests_failed++;
                $display("FAIL midrun_after_release %0d: {j,k,rdy,busy,done} got %b required 00100",
                         i, {j, k, cmd_ready, busy, done});
            end
        end
        run_cmd("after_midrun_set2", 2'b10, 2, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0] op;
        int         len;
        bit         noisy;
        for (int n = 0; n < 20; n++) begin
            op    = 2'($urandom_range(0, 3));
            len   = $urandom_range(0, 12);
            noisy = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_cmd("random", op, len, noisy);
        end
    endtask

    task automatic test_err();
        @(negedge clk);
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_before: err got %b required 0", err);
        end
        q_flip = 1'b1;
        @(negedge clk);
        q_flip = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (err !== CHECK_EN) begin
                tests_failed++;
                $display("FAIL err_sticky %0d: err got %b required %b", i, err, CHECK_EN);
            end
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_cleared_by_reset: err got %b required 0", err);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        m_q = 1'b0;
        run_cmd("after_err_toggle3", 2'b11, 3, 1'b0);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = 2'b00;
        cmd_len      = 8'd0;
        q_flip       = 1'b0;
        m_q          = 1'b0;

        test_reset();
        test_set_toggle();
        test_len_zero();
        test_valid_during_drive();
        test_reset_mid_run();
        test_random();
        test_err();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
